// File: rtl/store_narrow.sv
// MEM-stage store narrowing: word-aligns, lane-replicates and buffers SB/SH/SW in a DEPTH-entry FIFO; STORE_MERGE_EN enables tail merging.
// Latency: a store accepted on edge N is presented on mem_* from cycle N+1; misalign_o pulses the cycle after a rejected request.
// Backpressure: in_ready_o = !full (or a merge hit); mem_* held stable until mem_valid_o & mem_ready_i.
module store_narrow #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_addr_i,
    input  logic [31:0] in_data_i,
    input  logic [1:0]  in_size_i,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    output logic        misalign_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   addr_q  [DEPTH];
    logic [31:0]   wdata_q [DEPTH];
    logic [3:0]    be_q    [DEPTH];
    logic [31:0]   addr_d  [DEPTH];
    logic [31:0]   wdata_d [DEPTH];
    logic [3:0]    be_d    [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   out_addr_q, out_addr_d;
    logic [31:0]   out_wdata_q, out_wdata_d;
    logic [3:0]    out_be_q, out_be_d;
    logic          misalign_q, misalign_d;

    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_be;
    logic          req_bad;
    logic          full;
    logic          accept;
    logic          push;
    logic          pop;

    assign req_addr = {in_addr_i[31:2], 2'b00};

    always_comb begin
        req_wdata = in_data_i;
        req_be    = 4'b1111;
        req_bad   = 1'b0;
        case (in_size_i)
            2'b00: begin
                req_wdata = {4{in_data_i[7:0]}};
                req_be    = 4'b0001 << in_addr_i[1:0];
            end
            2'b01: begin
                req_wdata = {2{in_data_i[15:0]}};
                req_be    = in_addr_i[1] ? 4'b1100 : 4'b0011;
                req_bad   = in_addr_i[0];
            end
            2'b10:   req_bad = (in_addr_i[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    assign full        = (count_q == CW'(DEPTH));
    assign mem_valid_o = (count_q != '0);
    assign accept      = in_valid_i && in_ready_o;
    assign pop         = mem_valid_o && mem_ready_i;

`ifdef STORE_MERGE_EN
    logic [PW-1:0] tail_idx;
    logic          merge_hit;
    logic          merge;

    // Only merge when the tail is not the presented head, so mem_* never changes under the memory.
    assign tail_idx   = wr_ptr_q - PW'(1);
    assign merge_hit  = in_valid_i && !req_bad && (count_q >= CW'(2)) && (addr_q[tail_idx] == req_addr);
    assign in_ready_o = !full || merge_hit;
    assign merge      = accept && merge_hit && !flush_i;
    assign push       = accept && !req_bad && !merge_hit && !flush_i;
`else
    assign in_ready_o = !full;
    assign push       = accept && !req_bad && !flush_i;
`endif

    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_addr_d  = out_addr_q;
        out_wdata_d = out_wdata_q;
        out_be_d    = out_be_q;
        misalign_d  = accept && req_bad && !flush_i;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                addr_d[wr_ptr_q]  = req_addr;
                wdata_d[wr_ptr_q] = req_wdata;
                be_d[wr_ptr_q]    = req_be;
                wr_ptr_d          = wr_ptr_q + PW'(1);
            end
`ifdef STORE_MERGE_EN
            if (merge) begin
                for (int i = 0; i < 4; i++) begin
                    if (req_be[i]) begin
                        wdata_d[tail_idx][8*i +: 8] = req_wdata[8*i +: 8];
                    end
                end
                be_d[tail_idx] = be_q[tail_idx] | req_be;
            end
`endif
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end

        // Output registers track the post-update head; when empty they keep the last store.
        if (count_d != '0) begin
            out_addr_d  = addr_d[rd_ptr_d];
            out_wdata_d = wdata_d[rd_ptr_d];
            out_be_d    = be_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                be_q[i]    <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_addr_q  <= '0;
            out_wdata_q <= '0;
            out_be_q    <= '0;
            misalign_q  <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_addr_q  <= out_addr_d;
            out_wdata_q <= out_wdata_d;
            out_be_q    <= out_be_d;
            misalign_q  <= misalign_d;
        end
    end

    assign mem_addr_o  = out_addr_q;
    assign mem_wdata_o = out_wdata_q;
    assign mem_be_o    = out_be_q;
    assign misalign_o  = misalign_q;

endmodule
